// File: rtl/max_stream_argmax.sv
// Streaming argmax: accumulates a group of (value, idx, align) candidates
// and presents the winner plus a saturating candidate count on a valid/ready handshake.
module max_stream_argmax #(
  parameter int WIDTH      = 2,
  parameter int IDX_W      = 4,
  parameter int ALIGN_PRIO = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_value,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_align,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_max,
  output logic [IDX_W-1:0] o_max_idx,
  output logic             o_max_align,
  output logic [IDX_W:0]   o_count
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [IDX_W:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_first;
  logic [WIDTH-1:0] r_max;
  logic [IDX_W-1:0] r_max_idx;
  logic             r_max_align;
  logic [IDX_W:0]   r_count;
  logic             w_accept;
  logic             w_replace;

  assign w_accept = i_valid && (r_state == ACCUM);

  // Equal values only displace an unaligned incumbent when alignment priority is on.
  assign w_replace = r_first
                  || (i_value > r_max)
                  || ((ALIGN_PRIO != 0) && (i_value == r_max) && i_align && !r_max_align);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_accept && i_last) w_state_next = HOLD;
      HOLD:    if (i_ready)            w_state_next = ACCUM;
      default:                         w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ACCUM;
      r_first     <= 1'b1;
      r_max       <= '0;
      r_max_idx   <= '0;
      r_max_align <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_first <= 1'b0;
        if (w_replace) begin
          r_max       <= i_value;
          r_max_idx   <= i_idx;
          r_max_align <= i_align;
        end
        if (r_first)
          r_count <= (IDX_W+1)'(1);
        else if (r_count != CNT_MAX)
          r_count <= r_count + (IDX_W+1)'(1);
      end else if (r_state == HOLD && i_ready) begin
        r_first <= 1'b1;
      end
    end
  end

  assign o_ready     = (r_state == ACCUM);
  assign o_valid     = (r_state == HOLD);
  assign o_max       = r_max;
  assign o_max_idx   = r_max_idx;
  assign o_max_align = r_max_align;
  assign o_count     = r_count;

endmodule

// File: tb/tb_max_stream_argmax.sv
// Directed bench for max_stream_argmax: three instances (default, ALIGN_PRIO=0,
// IDX_W=2) share one input stream; each test checks the instance it targets.
module tb_max_stream_argmax;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] value;
  logic [3:0] idx;
  logic       align;
  logic       last;
  logic       rdy_in;

  logic       a_ready, a_valid, a_align;
  logic [1:0] a_max;
  logic [3:0] a_idx;
  logic [4:0] a_count;

  logic       b_ready, b_valid, b_align;
  logic [1:0] b_max;
  logic [3:0] b_idx;
  logic [4:0] b_count;

  logic       c_ready, c_valid, c_align;
  logic [1:0] c_max;
  logic [1:0] c_idx;
  logic [2:0] c_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  max_stream_argmax #(.WIDTH(2), .IDX_W(4), .ALIGN_PRIO(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(a_ready),
    .i_value(value), .i_idx(idx), .i_align(align), .i_last(last),
    .o_valid(a_valid), .i_ready(rdy_in), .o_max(a_max), .o_max_idx(a_idx),
    .o_max_align(a_align), .o_count(a_count));

  max_stream_argmax #(.WIDTH(2), .IDX_W(4), .ALIGN_PRIO(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(b_ready),
    .i_value(value), .i_idx(idx), .i_align(align), .i_last(last),
    .o_valid(b_valid), .i_ready(rdy_in), .o_max(b_max), .o_max_idx(b_idx),
    .o_max_align(b_align), .o_count(b_count));

  max_stream_argmax #(.WIDTH(2), .IDX_W(2), .ALIGN_PRIO(1)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(c_ready),
    .i_value(value), .i_idx(idx[1:0]), .i_align(align), .i_last(last),
    .o_valid(c_valid), .i_ready(rdy_in), .o_max(c_max), .o_max_idx(c_idx),
    .o_max_align(c_align), .o_count(c_count));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [1:0] v, input logic [3:0] ix,
                           input logic al, input logic lst);
    valid = 1'b1; value = v; idx = ix; align = al; last = lst;
    tick();
    valid = 1'b0; value = 2'bx; idx = 4'bx; align = 1'bx; last = 1'bx;
  endtask

  task automatic consume();
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    total++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      bad++;
      $display("FAIL consume: valid=%b ready=%b required valid=0 ready=1", a_valid, a_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; rdy_in = 1'b0; value = '0; idx = '0; align = 1'b0; last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({a_valid, a_ready, a_max, a_idx, a_align, a_count} !== {1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset: valid=%b ready=%b max=%0d idx=%0d align=%b count=%0d required 0 1 0 0 0 0",
               a_valid, a_ready, a_max, a_idx, a_align, a_count);
    end
  endtask

  task automatic test_basic_group();
    send_beat(2'd1, 4'd0, 1'b0, 1'b0);
    send_beat(2'd3, 4'd1, 1'b0, 1'b0);
    send_beat(2'd2, 4'd2, 1'b0, 1'b0);
    total++;
    if (a_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_valid: valid=%b required 0", a_valid);
    end
    send_beat(2'd3, 4'd3, 1'b0, 1'b1);
    total++;
    if ({a_valid, a_max, a_idx, a_align, a_count} !== {1'b1, 2'd3, 4'd1, 1'b0, 5'd4}) begin
      bad++;
      $display("FAIL basic_group: valid=%b max=%0d idx=%0d align=%b count=%0d required 1 3 1 0 4",
               a_valid, a_max, a_idx, a_align, a_count);
    end
    consume();
  endtask

  task automatic test_align_prio();
    send_beat(2'd2, 4'd5, 1'b0, 1'b0);
    send_beat(2'd2, 4'd6, 1'b1, 1'b0);
    send_beat(2'd2, 4'd7, 1'b1, 1'b1);
    total++;
    if ({a_valid, a_max, a_idx, a_align, a_count} !== {1'b1, 2'd2, 4'd6, 1'b1, 5'd3}) begin
      bad++;
      $display("FAIL align_prio1: valid=%b max=%0d idx=%0d align=%b count=%0d required 1 2 6 1 3",
               a_valid, a_max, a_idx, a_align, a_count);
    end
    total++;
    if ({b_valid, b_max, b_idx, b_align} !== {1'b1, 2'd2, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL align_prio0: valid=%b max=%0d idx=%0d align=%b required 1 2 5 0",
               b_valid, b_max, b_idx, b_align);
    end
    consume();
  endtask

  task automatic test_single_beat();
    send_beat(2'd0, 4'd9, 1'b1, 1'b1);
    total++;
    if ({a_valid, a_max, a_idx, a_align, a_count} !== {1'b1, 2'd0, 4'd9, 1'b1, 5'd1}) begin
      bad++;
      $display("FAIL single_beat: valid=%b max=%0d idx=%0d align=%b count=%0d required 1 0 9 1 1",
               a_valid, a_max, a_idx, a_align, a_count);
    end
    consume();
  endtask

  task automatic test_hold_backpressure();
    send_beat(2'd1, 4'd2, 1'b0, 1'b0);
    send_beat(2'd2, 4'd4, 1'b1, 1'b1);
    valid = 1'b1; value = 2'd3; idx = 4'd11; align = 1'b0; last = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      total++;
      if ({a_valid, a_ready, a_max, a_idx, a_align, a_count} !== {1'b1, 1'b0, 2'd2, 4'd4, 1'b1, 5'd2}) begin
        bad++;
        $display("FAIL hold_stable[%0d]: valid=%b ready=%b max=%0d idx=%0d align=%b count=%0d required 1 0 2 4 1 2",
                 i, a_valid, a_ready, a_max, a_idx, a_align, a_count);
      end
      tick();
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    total++;
    if ({a_valid, a_ready, a_max, a_idx, a_count} !== {1'b0, 1'b1, 2'd2, 4'd4, 5'd2}) begin
      bad++;
      $display("FAIL hold_release: valid=%b ready=%b max=%0d idx=%0d count=%0d required 0 1 2 4 2",
               a_valid, a_ready, a_max, a_idx, a_count);
    end
    tick();
    valid = 1'b0;
    total++;
    if ({a_valid, a_max, a_idx, a_align, a_count} !== {1'b1, 2'd3, 4'd11, 1'b0, 5'd1}) begin
      bad++;
      $display("FAIL next_group_first: valid=%b max=%0d idx=%0d align=%b count=%0d required 1 3 11 0 1",
               a_valid, a_max, a_idx, a_align, a_count);
    end
    consume();
  endtask

  task automatic test_saturation();
    logic [1:0] vals [10] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
    logic [3:0] ixs  [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1};
    for (int unsigned i = 0; i < 10; i++) begin
      send_beat(vals[i], ixs[i], 1'b0, (i == 9) ? 1'b1 : 1'b0);
      // Valid gap inside the group must not disturb the count
      if (i == 4) begin
        tick(); tick();
      end
    end
    total++;
    if ({c_valid, c_max, c_idx, c_count} !== {1'b1, 2'd3, 2'd2, 3'd7}) begin
      bad++;
      $display("FAIL saturate_w2: valid=%b max=%0d idx=%0d count=%0d required 1 3 2 7",
               c_valid, c_max, c_idx, c_count);
    end
    total++;
    if ({a_valid, a_max, a_idx, a_count} !== {1'b1, 2'd3, 4'd2, 5'd10}) begin
      bad++;
      $display("FAIL count_w4: valid=%b max=%0d idx=%0d count=%0d required 1 3 2 10",
               a_valid, a_max, a_idx, a_count);
    end
    consume();
  endtask

  task automatic test_reset_mid_group();
    send_beat(2'd3, 4'd8, 1'b1, 1'b0);
    send_beat(2'd2, 4'd9, 1'b0, 1'b0);
    rst = 1'b1;
    valid = 1'b1; value = 2'd3; idx = 4'd12; align = 1'b1; last = 1'b1;
    tick();
    rst = 1'b0; valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      total++;
      if ({a_valid, a_count, a_max} !== {1'b0, 5'd0, 2'd0}) begin
        bad++;
        $display("FAIL abort_no_valid[%0d]: valid=%b count=%0d max=%0d required 0 0 0",
                 i, a_valid, a_count, a_max);
      end
      tick();
    end
    send_beat(2'd1, 4'd1, 1'b0, 1'b0);
    send_beat(2'd2, 4'd2, 1'b0, 1'b1);
    total++;
    if ({a_valid, a_max, a_idx, a_align, a_count} !== {1'b1, 2'd2, 4'd2, 1'b0, 5'd2}) begin
      bad++;
      $display("FAIL post_abort_group: valid=%b max=%0d idx=%0d align=%b count=%0d required 1 2 2 0 2",
               a_valid, a_max, a_idx, a_align, a_count);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_group();
    test_align_prio();
    test_single_beat();
    test_hold_backpressure();
    test_saturation();
    test_reset_mid_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
